// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: active-low segment patterns ({g,f,e,d,c,b,a}),
// receiver FSM state encodings and anode helpers.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } scan_state_t;

    // Exactly one anode driven low means one digit is being shown.
    function automatic logic an_is_valid(input logic [3:0] an);
        logic ok;
        case (an)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Digit position of the single low anode; only meaningful when valid.
    function automatic logic [1:0] an_index(input logic [3:0] an);
        logic [1:0] idx;
        case (an)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational decode of an active-low seven-segment pattern to a hex nibble.
// Unknown patterns decode to 0 with vld low.
module seg7_to_hex
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nib,
    output logic       vld
);

    // Table lookup against the shared pattern constants.
    always_comb begin
        nib = 4'h0;
        vld = 1'b1;
        case (seg)
            SEG_0:   nib = 4'h0;
            SEG_1:   nib = 4'h1;
            SEG_2:   nib = 4'h2;
            SEG_3:   nib = 4'h3;
            SEG_4:   nib = 4'h4;
            SEG_5:   nib = 4'h5;
            SEG_6:   nib = 4'h6;
            SEG_7:   nib = 4'h7;
            SEG_8:   nib = 4'h8;
            SEG_9:   nib = 4'h9;
            SEG_A:   nib = 4'hA;
            SEG_B:   nib = 4'hB;
            SEG_C:   nib = 4'hC;
            SEG_D:   nib = 4'hD;
            SEG_E:   nib = 4'hE;
            SEG_F:   nib = 4'hF;
            default: begin
                nib = 4'h0;
                vld = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_rx.sv
// Receiver for a multiplexed four-digit seven-segment display. Captures each
// digit once its anode/segment/dp lines have been stable for SETTLE sampled
// cycles, and publishes complete four-digit frames.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no valid anode enabled; waiting for a digit to appear
// ST_SETTLE | valid anode seen; counting consecutive unchanged cycles
// ST_HOLD   | digit captured; ignore segment changes until anode moves
module seg_scan_rx
    import seg_pkg::*;
#(
    parameter int unsigned SETTLE = 4
) (
    input  logic        c_clk,
    input  logic        R,
    input  logic [3:0]  an,
    input  logic [6:0]  sseg,
    input  logic        dp,
    output logic [15:0] digits,
    output logic [3:0]  dp_pos,
    output logic        frame_valid,
    output logic        frame_err
);

    localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

    logic [3:0]  an_q,   an_p;
    logic [6:0]  sseg_q, sseg_p;
    logic        dp_q,   dp_p;

    scan_state_t state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic        cap;

    logic        an_ok;
    logic        an_changed;
    logic        inp_changed;
    logic [1:0]  cap_idx;
    logic [3:0]  cap_mask;

    logic [3:0]  dec_nib;
    logic        dec_vld;

    logic [15:0] shadow;
    logic [3:0]  shadow_dp;
    logic [3:0]  seen, seen_n;
    logic [3:0]  bad, bad_n;
    logic        frame_done;

    assign an_ok       = an_is_valid(an_q);
    assign an_changed  = (an_q != an_p);
    assign inp_changed = an_changed || (sseg_q != sseg_p) || (dp_q != dp_p);
    assign cap_idx     = an_index(an_q);
    assign cap_mask    = 4'b0001 << cap_idx;
    assign frame_done  = (seen == 4'b1111);

    seg7_to_hex u_dec (
        .seg (sseg_q),
        .nib (dec_nib),
        .vld (dec_vld)
    );

    // Input registration plus a one-cycle-older copy for stability compare.
    always_ff @(posedge c_clk) begin
        if (R) begin
            an_q   <= 4'hF;
            sseg_q <= 7'h7F;
            dp_q   <= 1'b1;
            an_p   <= 4'hF;
            sseg_p <= 7'h7F;
            dp_p   <= 1'b1;
        end else begin
            an_q   <= an;
            sseg_q <= sseg;
            dp_q   <= dp;
            an_p   <= an_q;
            sseg_p <= sseg_q;
            dp_p   <= dp_q;
        end
    end

    // FSM state and stability counter registers.
    always_ff @(posedge c_clk) begin
        if (R) begin
            state <= ST_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state, counter and capture decision.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cap     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (an_ok) begin
                    state_n = ST_SETTLE;
                    cnt_n   = 8'd1;
                end else begin
                    cnt_n   = 8'd0;
                end
            end
            ST_SETTLE: begin
                if (!an_ok) begin
                    state_n = ST_IDLE;
                    cnt_n   = 8'd0;
                end else if (inp_changed) begin
                    cnt_n   = 8'd1;
                end else begin
                    cnt_n   = cnt + 8'd1;
                end
            end
            ST_HOLD: begin
                if (an_changed) begin
                    if (an_ok) begin
                        state_n = ST_SETTLE;
                        cnt_n   = 8'd1;
                    end else begin
                        state_n = ST_IDLE;
                        cnt_n   = 8'd0;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = 8'd0;
            end
        endcase
        // A count that reaches the threshold (including a restart at 1 when
        // SETTLE is 1) captures on this edge.
        if (state_n == ST_SETTLE && cnt_n == SETTLE_CNT) begin
            cap     = 1'b1;
            state_n = ST_HOLD;
        end
    end

    // Seen/bad mask update: a completed frame clears them, a capture on the
    // same edge starts the next frame.
    always_comb begin
        seen_n = frame_done ? 4'b0000 : seen;
        bad_n  = frame_done ? 4'b0000 : bad;
        if (cap) begin
            seen_n = seen_n | cap_mask;
            bad_n  = (bad_n & ~cap_mask) | (dec_vld ? 4'b0000 : cap_mask);
        end
    end

    // Shadow capture and frame publication.
    always_ff @(posedge c_clk) begin
        if (R) begin
            shadow      <= 16'h0000;
            shadow_dp   <= 4'b0000;
            seen        <= 4'b0000;
            bad         <= 4'b0000;
            digits      <= 16'h0000;
            dp_pos      <= 4'b0000;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            seen        <= seen_n;
            bad         <= bad_n;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (cap) begin
                shadow[{cap_idx, 2'b00} +: 4] <= dec_nib;
                shadow_dp[cap_idx]            <= ~dp_q;
            end
            if (frame_done) begin
                if (bad == 4'b0000) begin
                    digits      <= shadow;
                    dp_pos      <= shadow_dp;
                    frame_valid <= 1'b1;
                end else begin
                    frame_err   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_rx.sv
// Scoreboard bench for seg_scan_rx: expected frames are queued as scans are
// driven and matched against frame_valid/frame_err pulses.
module tb_seg_scan_rx;

    logic        c_clk = 1'b0;
    logic        R;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic        dp;
    logic [15:0] digits;
    logic [3:0]  dp_pos;
    logic        frame_valid;
    logic        frame_err;

    typedef struct {
        logic        err;
        logic [15:0] dig;
        logic [3:0]  dpp;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_run  = 0;
    int   n_fail = 0;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg_scan_rx #(.SETTLE(4)) dut (
        .c_clk       (c_clk),
        .R           (R),
        .an          (an),
        .sseg        (sseg),
        .dp          (dp),
        .digits      (digits),
        .dp_pos      (dp_pos),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    always #5 c_clk = ~c_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Apply one input set for n clock cycles (inputs change on negedge).
    task automatic drive(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
        @(negedge c_clk);
        an   = a;
        sseg = s;
        dp   = d;
        repeat (n - 1) @(negedge c_clk);
    endtask

    // Scan positions 0..3 with val nibbles; dpl bit = lit; bad_pos gets blank.
    task automatic scan(input logic [15:0] val, input logic [3:0] dpl, input int n,
                        input int gap, input int bad_pos);
        logic [3:0] a;
        logic [6:0] s;
        for (int i = 0; i < 4; i++) begin
            a = ~(4'b0001 << i);
            s = (i == bad_pos) ? 7'h7F : seg_tab[val[4*i +: 4]];
            drive(a, s, ~dpl[i], n);
            if (gap > 0) drive(4'hF, 7'h7F, 1'b1, gap);
        end
        drive(4'hF, 7'h7F, 1'b1, 4);
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while (sb.size() != 0 && k < 60) begin
            @(negedge c_clk);
            k++;
        end
        chk(tag, sb.size(), 0);
    endtask

    task automatic push(input logic err, input logic [15:0] dig, input logic [3:0] dpp);
        exp_t x;
        x.err = err;
        x.dig = dig;
        x.dpp = dpp;
        sb.push_back(x);
    endtask

    // Monitor: every frame pulse must match the head of the scoreboard.
    always @(negedge c_clk) begin
        if (frame_valid && frame_err) chk("both_pulse", 1, 0);
        if (frame_valid || frame_err) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'd0, frame_valid, frame_err}, 0);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind_err", {31'd0, frame_err}, {31'd0, e.err});
                chk("frame_digits", {16'd0, digits}, {16'd0, e.dig});
                chk("frame_dp_pos", {28'd0, dp_pos}, {28'd0, e.dpp});
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        R    = 1'b1;
        an   = 4'hF;
        sseg = 7'h7F;
        dp   = 1'b1;
        repeat (3) @(negedge c_clk);
        chk("rst_digits", {16'd0, digits}, 0);
        chk("rst_dp_pos", {28'd0, dp_pos}, 0);
        chk("rst_fv", {31'd0, frame_valid}, 0);
        chk("rst_fe", {31'd0, frame_err}, 0);
        R = 1'b0;

        // Digits held only 3 cycles: nothing captured.
        scan(16'h0123, 4'b0000, 3, 0, -1);
        scan(16'h4567, 4'b1111, 3, 0, -1);
        drive(4'hF, 7'h7F, 1'b1, 10);
        chk("short_digits", {16'd0, digits}, 0);
        chk("short_dp_pos", {28'd0, dp_pos}, 0);

        // Basic frame with dp on position 2.
        push(1'b0, 16'h0123, 4'b0100);
        scan(16'h0123, 4'b0100, 16, 0, -1);
        drain("drain_basic");

        // Blank pattern on position 2: error frame, outputs retained.
        push(1'b1, 16'h0123, 4'b0100);
        scan(16'h4567, 4'b0000, 16, 0, 2);
        drain("drain_err");
        chk("err_digits_kept", {16'd0, digits}, 32'h0123);

        // Blanking gaps between digits.
        push(1'b0, 16'h9999, 4'b0000);
        scan(16'h9999, 4'b0000, 8, 5, -1);
        drain("drain_gaps");

        // Exactly SETTLE cycles per digit is enough.
        push(1'b0, 16'h2FE8, 4'b1001);
        scan(16'h2FE8, 4'b1001, 4, 0, -1);
        drain("drain_boundary");

        // Partial frame discarded by reset.
        drive(4'b1011, seg_tab[7], 1'b1, 8);
        drive(4'b0111, seg_tab[7], 1'b1, 8);
        drive(4'hF, 7'h7F, 1'b1, 2);
        @(negedge c_clk);
        R = 1'b1;
        @(negedge c_clk);
        R = 1'b0;
        chk("midrst_digits", {16'd0, digits}, 0);
        push(1'b0, 16'hDCBA, 4'b0000);
        scan(16'hDCBA, 4'b0000, 8, 0, -1);
        drain("drain_reset");

        // Segment change after capture in the same window is ignored.
        push(1'b0, 16'h6541, 4'b0000);
        drive(4'b1110, seg_tab[1], 1'b1, 8);
        drive(4'b1110, seg_tab[7], 1'b0, 8);
        drive(4'b1101, seg_tab[4], 1'b1, 16);
        drive(4'b1011, seg_tab[5], 1'b1, 16);
        drive(4'b0111, seg_tab[6], 1'b1, 16);
        drive(4'hF, 7'h7F, 1'b1, 4);
        drain("drain_recap");

        drive(4'hF, 7'h7F, 1'b1, 20);
        chk("final_sb_empty", sb.size(), 0);
        chk("final_digits", {16'd0, digits}, 32'h6541);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
